alarm_event_tx: RTL and testbench

Serial event reporter for the alarm controller. It monitors the controller's 2-bit alarm state (OFF/ARMED/TRIGGERED/ALARM_ON) and transmits one UART 8N1 frame for every state change, so an external logger can track the alarm. It is the transmit/report end of the alarm status path and drives one dedicated output pin.

---
 rtl/alarm_event_tx.sv | 183 ++++++++++++++++++
 tb/tb_alarm_event_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_event_tx.sv
// UART 8N1 event reporter: sends one frame {1010, prev, new} for every alarm state change,
// with a one-deep pending slot that coalesces bursts and flags overrun.
module alarm_event_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [1:0] alarm_state,
   input  logic       overrun_clr,
   output logic       tx,
   output logic       busy,
   output logic       overrun,
   output logic [7:0] event_count
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [BAUD_W-1:0]   baud_r, baud_s;
   logic [2:0]          bit_r, bit_s;
   logic [7:0]          shift_r, shift_s;
   logic                tx_s;
   logic                load_s;
   logic                baud_end_s;
   logic                change_s;
   logic                ovr_set_s;
   logic [1:0]          last_state_r;
   logic [1:0]          slot_prev_r;
   logic [1:0]          slot_new_r;
   logic                slot_valid_r;
   logic                tx_r;
   logic                busy_r;
   logic                overrun_r;
   logic [7:0]          event_count_r;

   assign baud_end_s = (baud_r == BAUD_LAST);
   assign change_s   = ena && (alarm_state != last_state_r);
   // A change that finds the slot still occupied merges into it instead of queueing.
   assign ovr_set_s  = change_s && slot_valid_r && !load_s;

   // Next-state, baud/bit counters, shift register and next line level.
   always_comb begin
      state_s = state_r;
      baud_s  = baud_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      load_s  = 1'b0;
      tx_s    = 1'b1;
      case (state_r)
         ST_IDLE: begin
            baud_s = '0;
            bit_s  = 3'd0;
            if (slot_valid_r) begin
               load_s  = 1'b1;
               shift_s = {4'b1010, slot_prev_r, slot_new_r};
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_end_s) begin
               baud_s  = '0;
               state_s = ST_DATA;
            end else begin
               baud_s = baud_r + BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_s  = '0;
               shift_s = {1'b0, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  bit_s   = 3'd0;
                  state_s = ST_STOP;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               baud_s = baud_r + BAUD_ONE;
            end
         end
         ST_STOP: begin
            if (baud_end_s) begin
               baud_s = '0;
               // Chain straight into the next frame when one is waiting.
               if (slot_valid_r) begin
                  load_s  = 1'b1;
                  shift_s = {4'b1010, slot_prev_r, slot_new_r};
                  state_s = ST_START;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               baud_s = baud_r + BAUD_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            baud_s  = '0;
            bit_s   = 3'd0;
         end
      endcase
      if (state_s == ST_START) begin
         tx_s = 1'b0;
      end else if (state_s == ST_DATA) begin
         tx_s = shift_s[0];
      end else begin
         tx_s = 1'b1;
      end
   end

   // FSM state, counters and registered line outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         baud_r        <= '0;
         bit_r         <= 3'd0;
         shift_r       <= 8'd0;
         tx_r          <= 1'b1;
         busy_r        <= 1'b0;
         event_count_r <= 8'd0;
      end else begin
         state_r <= state_s;
         baud_r  <= baud_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         tx_r    <= tx_s;
         busy_r  <= (state_s != ST_IDLE);
         if (load_s) begin
            event_count_r <= event_count_r + 8'd1;
         end
      end
   end

   // Change tracking and the one-deep pending slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_state_r <= 2'b00;
         slot_prev_r  <= 2'b00;
         slot_new_r   <= 2'b00;
         slot_valid_r <= 1'b0;
      end else begin
         last_state_r <= alarm_state;
         if (change_s) begin
            slot_new_r   <= alarm_state;
            slot_valid_r <= 1'b1;
            if (!slot_valid_r || load_s) begin
               slot_prev_r <= last_state_r;
            end
         end else if (load_s) begin
            slot_valid_r <= 1'b0;
         end
      end
   end

   // Sticky overrun flag; a new overrun beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_r <= 1'b0;
      end else if (ovr_set_s) begin
         overrun_r <= 1'b1;
      end else if (overrun_clr) begin
         overrun_r <= 1'b0;
      end
   end

   assign tx          = tx_r;
   assign busy        = busy_r;
   assign overrun     = overrun_r;
   assign event_count = event_count_r;

endmodule

// File: tb/tb_alarm_event_tx.sv
// Bench for alarm_event_tx: table of single events, directed multi-cycle sequences,
// and random stimulus against a cycle-timeline reference model.
module tb_alarm_event_tx;

   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [1:0] alarm_state;
   logic       overrun_clr;
   logic       tx;
   logic       busy;
   logic       overrun;
   logic [7:0] event_count;

   alarm_event_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .alarm_state (alarm_state),
      .overrun_clr (overrun_clr),
      .tx          (tx),
      .busy        (busy),
      .overrun     (overrun),
      .event_count (event_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: each frame is a 160-cycle window starting at the edge the slot is taken.
   int         cyc = 0;
   int         free_at = 0;
   int         fstart = 0;
   logic [1:0] m_last, m_prev, m_new;
   logic       m_valid, m_ovr;
   logic [7:0] m_cnt, m_byte;
   bit         m_cons, m_chg, m_oset;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
         m_last = 2'b00; m_valid = 1'b0; m_ovr = 1'b0; m_cnt = 8'd0; free_at = cyc;
      end else begin
         m_cons = m_valid && (cyc >= free_at);
         if (m_cons) begin
            m_byte  = {4'hA, m_prev, m_new};
            m_cnt   = m_cnt + 8'd1;
            fstart  = cyc;
            free_at = cyc + FRAME;
            m_valid = 1'b0;
         end
         m_chg  = ena && (alarm_state != m_last);
         m_oset = 1'b0;
         if (m_chg) begin
            if (!m_valid) begin
               m_prev = m_last; m_new = alarm_state; m_valid = 1'b1;
            end else begin
               m_new = alarm_state; m_oset = 1'b1;
            end
         end
         if (m_oset) m_ovr = 1'b1;
         else if (overrun_clr) m_ovr = 1'b0;
         m_last = alarm_state;
      end
   end

   // Per-cycle comparison of all outputs against the model timeline.
   logic exp_tx, exp_busy;
   int   pk, pb;
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         exp_busy = (cyc < free_at);
         exp_tx   = 1'b1;
         if (exp_busy) begin
            pk = cyc - fstart;
            pb = pk / CPB;
            if (pb == 0) exp_tx = 1'b0;
            else if (pb == 9) exp_tx = 1'b1;
            else exp_tx = m_byte[pb-1];
         end
         n_cmp++;
         if ({tx, busy, overrun, event_count} !== {exp_tx, exp_busy, m_ovr, m_cnt}) begin
            n_bad++;
            if (n_bad <= 20)
               $display("FAIL cycle_%0d: tx/busy/ovr/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                        cyc, tx, busy, overrun, event_count, exp_tx, exp_busy, m_ovr, m_cnt);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for a start bit, decodes nf frames at bit centres and counts busy cycles.
   task automatic capture(input int nf, output logic [15:0] bytes, output int busy_cyc,
                          output int lat, output int ferr);
      int k, pos, bi;
      bytes = 16'h0; busy_cyc = 0; lat = 0; ferr = 0; k = 0;
      while (tx !== 1'b0 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      while (busy === 1'b1 && k < 4 * FRAME) begin
         if (k < nf * FRAME) begin
            pos = k % FRAME;
            if (pos % CPB == CPB / 2) begin
               bi = pos / CPB;
               if (bi == 0 && tx !== 1'b0) ferr++;
               else if (bi == 9 && tx !== 1'b1) ferr++;
               else if (bi >= 1 && bi <= 8) bytes[(k / FRAME) * 8 + bi - 1] = tx;
            end
         end
         busy_cyc++;
         k++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic       en;
      logic [1:0] pre;
      logic [1:0] nxt;
      logic       frame;
      logic [7:0] byte_exp;
   } vec_t;

   vec_t        tbl[9];
   logic [15:0] bytes;
   int          bc, lat, fe, lows, guard;
   logic [7:0]  cnt0;
   logic [1:0]  s;

   initial begin
      tbl[0] = '{1'b1, 2'b00, 2'b01, 1'b1, 8'hA1};
      tbl[1] = '{1'b1, 2'b01, 2'b10, 1'b1, 8'hA6};
      tbl[2] = '{1'b1, 2'b10, 2'b11, 1'b1, 8'hAB};
      tbl[3] = '{1'b1, 2'b11, 2'b00, 1'b1, 8'hAC};
      tbl[4] = '{1'b0, 2'b00, 2'b01, 1'b0, 8'h00};
      tbl[5] = '{1'b1, 2'b01, 2'b11, 1'b1, 8'hA7};
      tbl[6] = '{1'b1, 2'b11, 2'b10, 1'b1, 8'hAE};
      tbl[7] = '{1'b1, 2'b10, 2'b00, 1'b1, 8'hA8};
      tbl[8] = '{1'b1, 2'b00, 2'b00, 1'b0, 8'h00};

      rst = 1'b1; ena = 1'b0; alarm_state = 2'b00; overrun_clr = 1'b0;
      tick(2);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      check("reset_count", {24'd0, event_count}, 32'd0);
      chk_en = 1'b1;
      rst = 1'b0;
      tick(50);
      check("post_reset_idle", {31'd0, busy}, 32'd0);

      // Single events from idle, including ena-gated and no-change rows.
      for (int i = 0; i < 9; i++) begin
         ena = 1'b0; alarm_state = tbl[i].pre;
         tick(3);
         cnt0 = event_count;
         ena = tbl[i].en; alarm_state = tbl[i].nxt;
         if (tbl[i].frame) begin
            capture(1, bytes, bc, lat, fe);
            check($sformatf("tbl%0d_byte", i), {24'd0, bytes[7:0]}, {24'd0, tbl[i].byte_exp});
            check($sformatf("tbl%0d_latency", i), lat, 32'd2);
            check($sformatf("tbl%0d_busy_cycles", i), bc, FRAME);
            check($sformatf("tbl%0d_framing", i), fe, 32'd0);
            check($sformatf("tbl%0d_count", i), {24'd0, event_count}, {24'd0, cnt0 + 8'd1});
         end else begin
            tick(FRAME + 20);
            check($sformatf("tbl%0d_no_frame", i), {31'd0, busy}, 32'd0);
            check($sformatf("tbl%0d_count", i), {24'd0, event_count}, {24'd0, cnt0});
         end
         tick(1);
      end

      // Back-to-back: second change during frame 1 chains without a gap.
      ena = 1'b0; alarm_state = 2'b00; tick(3);
      cnt0 = event_count; ena = 1'b1; alarm_state = 2'b01;
      fork
         capture(2, bytes, bc, lat, fe);
         begin tick(40); alarm_state = 2'b10; end
      join
      check("b2b_byte1", {24'd0, bytes[7:0]}, 32'hA1);
      check("b2b_byte2", {24'd0, bytes[15:8]}, 32'hA6);
      check("b2b_busy_cycles", bc, 2 * FRAME);
      check("b2b_framing", fe, 32'd0);
      check("b2b_overrun", {31'd0, overrun}, 32'd0);
      check("b2b_count", {24'd0, event_count}, {24'd0, cnt0 + 8'd2});

      // Coalesce: two changes during frame 1 merge into one frame and flag overrun.
      ena = 1'b0; alarm_state = 2'b00; tick(3);
      ena = 1'b1; alarm_state = 2'b01;
      fork
         capture(2, bytes, bc, lat, fe);
         begin tick(30); alarm_state = 2'b10; tick(10); alarm_state = 2'b11; end
      join
      check("coal_byte1", {24'd0, bytes[7:0]}, 32'hA1);
      check("coal_byte2", {24'd0, bytes[15:8]}, 32'hA7);
      check("coal_busy_cycles", bc, 2 * FRAME);
      tick(5);
      check("coal_overrun_set", {31'd0, overrun}, 32'd1);
      overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0; tick(1);
      check("coal_overrun_clr", {31'd0, overrun}, 32'd0);

      // Reset in the middle of data bit 4.
      ena = 1'b0; alarm_state = 2'b00; tick(3);
      ena = 1'b1; alarm_state = 2'b01;
      guard = 0;
      while (tx !== 1'b0 && guard < 400) begin tick(1); guard++; end
      check("rst_mid_started", {31'd0, tx}, 32'd0);
      tick(CPB * 5 + CPB / 2);
      rst = 1'b1; alarm_state = 2'b00;
      tick(1);
      check("rst_mid_tx", {31'd0, tx}, 32'd1);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_count", {24'd0, event_count}, 32'd0);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (tx !== 1'b1) lows++;
      end
      check("rst_mid_no_resume", lows, 32'd0);

      // 256 events wrap event_count back to 0.
      s = 2'b00;
      for (int i = 0; i < 256; i++) begin
         cnt0 = event_count;
         s = s + 2'b01; alarm_state = s;
         guard = 0;
         while (event_count === cnt0 && guard < 400) begin tick(1); guard++; end
         if (guard >= 400) check("wrap_timeout", guard, 32'd0);
         if (i == 254) check("wrap_255", {24'd0, event_count}, 32'd255);
      end
      check("wrap_0", {24'd0, event_count}, 32'd0);
      guard = 0;
      while (busy !== 1'b0 && guard < 400) begin tick(1); guard++; end

      // Random stimulus, checked cycle by cycle against the model.
      for (int i = 0; i < 8000; i++) begin
         rst         = ($urandom_range(0, 2999) == 0);
         overrun_clr = ($urandom_range(0, 19) == 0);
         ena         = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 39) == 0) alarm_state = 2'($urandom_range(0, 3));
         tick(1);
      end
      rst = 1'b0; overrun_clr = 1'b0; ena = 1'b0;
      tick(2 * FRAME + 10);
      check("final_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
